rv32_fetch_unit: RTL and testbench

//  Instruction fetch stage directly downstream of programCounter.

---
 rtl/rv32_pkg.sv | 20 ++
 rtl/rv32_fetch_fifo.sv | 50 +++++
 rtl/rv32_fetch_unit.sv | 139 +++++++++++++
 tb/tb_rv32_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared constants and types for the RV32 instruction fetch stage.
package rv32_pkg;

   localparam int XLEN = 32;

   // Canonical RV32 no-op (addi x0, x0, 0); substituted for faulting fetches.
   localparam logic [31:0] RV32_NOP = 32'h0000_0013;

   // Fetch FSM: RUN issues fetches, DRAIN swallows responses that were in flight at a flush.
   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } fetch_state_e;

   // Instructions are word aligned; anything else faults without touching memory.
   function automatic logic pc_aligned(input logic [1:0] low_bits);
      return low_bits == 2'b00;
   endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Small synchronous FIFO with synchronous clear; storage is reset so outputs start at zero.
module rv32_fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign dout = mem[rd_ptr];

   // Storage, pointers and occupancy; clear discards everything, including a same-cycle push/pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/rv32_fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests, pairs responses with their PC,
// buffers results for decode, and discards stale work on a redirect flush.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
// imem_req_valid may drop without a transfer only on flush or when entering DRAIN;
// imem responses carry no ready and always find a free slot because fetches are credit limited.
module rv32_fetch_unit #(
   parameter int XLEN       = rv32_pkg::XLEN,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [XLEN-1:0]        pc_value,
   output logic                   pc_hold,
   input  logic                   flush,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [XLEN-1:0]        imem_req_addr,
   input  logic                   imem_rsp_valid,
   input  logic [31:0]            imem_rsp_data,
   input  logic                   imem_rsp_err,
   output logic                   if_valid,
   input  logic                   if_ready,
   output logic [31:0]            if_instr,
   output logic [XLEN-1:0]        if_pc,
   output logic                   if_fault,
   output rv32_pkg::fetch_state_e fsm_state
);

   import rv32_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = 32 + XLEN + 1;

   fetch_state_e    state_q, state_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   tag_count, out_count;
   logic [CW-1:0]   in_flight, after_rsp;
   logic [CW:0]     credits;
   logic            credit_free, aligned;
   logic            tag_push, tag_pop, out_push, out_pop, mis_push;
   logic [XLEN-1:0] tag_dout;
   logic [OW-1:0]   out_din, out_dout;

   // In RUN every outstanding fetch owns a tag entry; in DRAIN tags are gone and drop_q tracks them.
   assign in_flight   = (state_q == ST_DRAIN) ? drop_q : tag_count;
   assign after_rsp   = in_flight - CW'(imem_rsp_valid);
   assign credits     = {1'b0, in_flight} + {1'b0, out_count};
   assign credit_free = credits < (CW+1)'(FIFO_DEPTH);
   assign aligned     = pc_aligned(pc_value[1:0]);

   assign imem_req_addr = pc_value;
   assign if_valid      = (out_count != '0);
   assign {if_instr, if_pc, if_fault} = out_dout;
   assign fsm_state     = state_q;

   // FSM state and drain counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // Next state, request issue, FIFO control and PC hold.
   // A misaligned PC is only written once nothing is in flight, so it cannot overtake older fetches
   // nor collide with a response push. A response during a flush while draining still counts down.
   always_comb begin
      state_d        = state_q;
      drop_d         = drop_q;
      imem_req_valid = 1'b0;
      pc_hold        = 1'b1;
      mis_push       = 1'b0;
      tag_push       = 1'b0;
      tag_pop        = 1'b0;
      out_push       = 1'b0;
      out_pop        = 1'b0;
      out_din        = '0;
      unique case (state_q)
         ST_RUN: begin
            if (flush) begin
               if (after_rsp != '0) begin
                  state_d = ST_DRAIN;
                  drop_d  = after_rsp;
               end
            end else if (reset_n) begin
               imem_req_valid = aligned && credit_free;
               mis_push       = !aligned && credit_free && (tag_count == '0);
               tag_push       = imem_req_valid && imem_req_ready;
               if (imem_rsp_valid) begin
                  tag_pop  = 1'b1;
                  out_push = 1'b1;
                  out_din  = {(imem_rsp_err ? RV32_NOP : imem_rsp_data), tag_dout, imem_rsp_err};
               end else if (mis_push) begin
                  out_push = 1'b1;
                  out_din  = {RV32_NOP, pc_value, 1'b1};
               end
               out_pop = if_valid && if_ready;
               pc_hold = !(tag_push || mis_push);
            end
         end
         ST_DRAIN: begin
            if (imem_rsp_valid) begin
               drop_d = drop_q - CW'(1);
               if (drop_q == CW'(1)) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   rv32_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (flush),
      .push    (tag_push),
      .din     (pc_value),
      .pop     (tag_pop),
      .dout    (tag_dout),
      .count   (tag_count)
   );

   rv32_fetch_fifo #(.WIDTH(OW), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (flush),
      .push    (out_push),
      .din     (out_din),
      .pop     (out_pop),
      .dout    (out_dout),
      .count   (out_count)
   );

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Bench for rv32_fetch_unit: behavioural imem responder, scoreboard of expected decode outputs.
module tb_rv32_fetch_unit;

   import rv32_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n = 1'b0;
   logic [31:0] pc_value = '0;
   logic        flush = 1'b0;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        imem_rsp_err = 1'b0;
   logic        if_ready = 1'b0;

   logic         pc_hold, imem_req_valid, if_valid, if_fault;
   logic [31:0]  imem_req_addr, if_instr, if_pc;
   fetch_state_e fsm_state;

   rv32_fetch_unit #(.XLEN(32), .FIFO_DEPTH(2)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pc_value       (pc_value),
      .pc_hold        (pc_hold),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_fault       (if_fault),
      .fsm_state      (fsm_state)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int rsp_delay = 0;
   int last_rdy  = 0;
   bit rand_ready = 1'b0;

   logic [64:0] exp_q[$];
   logic [31:0] mem_q[$];
   int          mem_rdy_q[$];

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- memory contents ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0)  return 32'h0050_0093;
      if (a == 32'h20) return 32'hdead_beef;
      return a ^ 32'h1357_9bdf;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return a == 32'h20;
   endfunction

   function automatic logic [64:0] expect_of(input logic [31:0] pc);
      if (pc[1:0] != 2'b00) return {RV32_NOP, pc, 1'b1};
      if (mem_err(pc))      return {RV32_NOP, pc, 1'b1};
      return {mem_word(pc), pc, 1'b0};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // imem responder: in-order, at least one cycle after accept, one response per cycle
   always @(posedge clk) begin
      logic [31:0] a;
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      if (reset_n && mem_q.size() > 0 && mem_rdy_q[0] <= cyc) begin
         a = mem_q.pop_front();
         void'(mem_rdy_q.pop_front());
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(a);
         imem_rsp_err   = mem_err(a);
      end
   end

   // monitor / scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      logic [64:0] e;
      int rdy;
      if (!reset_n) begin
         exp_q.delete();
         mem_q.delete();
         mem_rdy_q.delete();
         last_rdy = 0;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            check("req_addr", 96'(imem_req_addr), 96'(pc_value));
            rdy = cyc + 1 + rsp_delay;
            if (rdy <= last_rdy) rdy = last_rdy + 1;
            last_rdy = rdy;
            mem_q.push_back(imem_req_addr);
            mem_rdy_q.push_back(rdy);
         end
         if (flush) begin
            exp_q.delete();
         end else if (if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected", 96'(if_pc), 96'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               check("sb_data", 96'({if_instr, if_pc, if_fault}), 96'(e));
            end
         end
         if (!pc_hold) exp_q.push_back(expect_of(pc_value));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one PC until consumed, then park on an aligned idle PC with no memory ready.
   task automatic issue(input logic [31:0] addr);
      bit ok = 1'b0;
      pc_value = addr;
      imem_req_ready = 1'b1;
      if (rand_ready) if_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!pc_hold) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (rand_ready) if_ready = ($urandom_range(0, 3) != 0);
      end
      if (!ok) check("issue_timeout", 96'(pc_hold), 96'(0));
      @(posedge clk);
      #1;
      imem_req_ready = 1'b0;
      if (addr[1:0] != 2'b00) pc_value = 32'h0;
   endtask

   task automatic wait_if_valid(input string tag);
      bit ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (if_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check(tag, 96'(if_valid), 96'(1));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a;
      bit ok;

      // 1: reset values, then first fetch at pc 0
      #3;
      check("rst_if_valid", 96'(if_valid), 96'(0));
      check("rst_req_valid", 96'(imem_req_valid), 96'(0));
      check("rst_pc_hold", 96'(pc_hold), 96'(1));
      check("rst_if_instr", 96'(if_instr), 96'(0));
      check("rst_if_pc", 96'(if_pc), 96'(0));
      check("rst_if_fault", 96'(if_fault), 96'(0));
      check("rst_state", 96'(fsm_state), 96'(ST_RUN));
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      check("rel_req_valid", 96'(imem_req_valid), 96'(1));
      issue(32'h0);
      #1;
      check("no_fall_through", 96'(if_valid), 96'(0));
      tick();
      #1;
      check("t1_if_valid", 96'(if_valid), 96'(1));
      check("t1_if_pc", 96'(if_pc), 96'(0));
      check("t1_if_instr", 96'(if_instr), 96'(32'h0050_0093));
      check("t1_if_fault", 96'(if_fault), 96'(0));
      if_ready = 1'b1;
      tick();
      tick();
      if_ready = 1'b0;

      // 2: backpressure from decode exhausts credits
      issue(32'h0);
      issue(32'h4);
      pc_value = 32'h8;
      #1;
      check("bp_req_valid", 96'(imem_req_valid), 96'(0));
      check("bp_pc_hold", 96'(pc_hold), 96'(1));
      tick();
      tick();
      tick();
      if_ready = 1'b1;
      #1;
      check("bp_before_pop", 96'(imem_req_valid), 96'(0));
      tick();
      #1;
      check("bp_after_pop", 96'(imem_req_valid), 96'(1));
      check("bp_after_addr", 96'(imem_req_addr), 96'(32'h8));

      // 3: flush with two fetches in flight
      rsp_delay = 4;
      issue(32'h8);
      issue(32'hC);
      pc_value = 32'hff00_ff00;
      flush = 1'b1;
      #1;
      check("fl_req_valid", 96'(imem_req_valid), 96'(0));
      check("fl_pc_hold", 96'(pc_hold), 96'(1));
      tick();
      flush = 1'b0;
      #1;
      check("fl_state", 96'(fsm_state), 96'(ST_DRAIN));
      check("fl_drain_hold", 96'(pc_hold), 96'(1));
      rsp_delay = 0;
      issue(32'hff00_ff00);
      wait_if_valid("fl_wait");
      check("fl_if_pc", 96'(if_pc), 96'(32'hff00_ff00));
      tick();

      // 4: misaligned PC goes straight to decode as a fault
      pc_value = 32'h102;
      #1;
      check("mis_no_req", 96'(imem_req_valid), 96'(0));
      check("mis_consumed", 96'(pc_hold), 96'(0));
      issue(32'h102);
      #1;
      check("mis_if_valid", 96'(if_valid), 96'(1));
      check("mis_if_fault", 96'(if_fault), 96'(1));
      check("mis_if_instr", 96'(if_instr), 96'(RV32_NOP));
      check("mis_if_pc", 96'(if_pc), 96'(32'h102));
      tick();

      // 5: memory access error
      issue(32'h20);
      wait_if_valid("err_wait");
      check("err_if_fault", 96'(if_fault), 96'(1));
      check("err_if_instr", 96'(if_instr), 96'(RV32_NOP));
      check("err_if_pc", 96'(if_pc), 96'(32'h20));
      tick();

      // random traffic: mixed latency, decode stalls, occasional misaligned PCs
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rsp_delay = $urandom_range(0, 2);
         a = 32'h1000 + ($urandom_range(0, 63) << 2);
         if ($urandom_range(0, 7) == 0) a = a + 32'h2;
         issue(a);
      end
      rand_ready = 1'b0;
      if_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && mem_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("rand_drain", 96'(exp_q.size()), 96'(0));
      tick();

      // 6: reset with one fetch in flight and one buffered
      if_ready = 1'b0;
      rsp_delay = 0;
      issue(32'h40);
      rsp_delay = 6;
      issue(32'h44);
      reset_n = 1'b0;
      #1;
      check("mid_rst_if_valid", 96'(if_valid), 96'(0));
      check("mid_rst_req_valid", 96'(imem_req_valid), 96'(0));
      check("mid_rst_pc_hold", 96'(pc_hold), 96'(1));
      check("mid_rst_if_instr", 96'(if_instr), 96'(0));
      tick();
      tick();
      reset_n = 1'b1;
      rsp_delay = 0;
      if_ready = 1'b1;
      issue(32'h0);
      wait_if_valid("post_rst_wait");
      check("post_rst_if_pc", 96'(if_pc), 96'(32'h0));
      check("post_rst_if_instr", 96'(if_instr), 96'(32'h0050_0093));
      tick();
      tick();
      check("final_drain", 96'(exp_q.size()), 96'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
